// File: rtl/coefficient_pkg.sv
// Shared types and default sizing for the coefficient load controller.
package coefficient_pkg;

  localparam int LENGTH_DEF     = 20;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int SUM_WIDTH_DEF  = DATA_WIDTH_DEF + ADDR_WIDTH_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_LOAD,
    S_DONE
  } state_e;

endpackage

// File: rtl/coefficient_load_controller.sv
// Streams the coefficient table from a synchronous-read ROM into the FIR filter
// over a valid/ready handshake. COEFF_CHECKSUM_EN adds a running coefficient sum.
//
// state | meaning
// IDLE  | waiting for start, all outputs cleared
// ADDR  | romAddress presented; ROM samples it this cycle
// READ  | romData valid; captured into coefficient_out
// LOAD  | coefficient offered to the filter until filterReady
// DONE  | table fully accepted; filterSetFlag held until next start
module coefficient_load_controller
  import coefficient_pkg::*;
#(
  parameter int LENGTH     = LENGTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic [ADDR_WIDTH-1:0]        romAddress,
  input  logic signed [DATA_WIDTH-1:0] romData,
  input  logic                         filterReady,
  output logic signed [DATA_WIDTH-1:0] coefficient_out,
  output logic                         coefficientValid,
  output logic                         busy,
  output logic                         filterSetFlag
`ifdef COEFF_CHECKSUM_EN
  ,
  output logic signed [DATA_WIDTH+ADDR_WIDTH-1:0] coefficientSum
`endif
);

  localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic signed [DATA_WIDTH-1:0]   coeff_q, coeff_d;
  logic                           valid_q, valid_d;
  logic                           busy_q, busy_d;
  logic                           flag_q, flag_d;
`ifdef COEFF_CHECKSUM_EN
  logic signed [SUM_W-1:0]        sum_q, sum_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    coeff_d = coeff_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    flag_d  = flag_q;
`ifdef COEFF_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          flag_d  = 1'b0;
`ifdef COEFF_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_READ;
      S_READ: begin
        coeff_d = romData;
        valid_d = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Address is held while stalled so the table index tracks the offered coefficient.
        if (filterReady) begin
          valid_d = 1'b0;
`ifdef COEFF_CHECKSUM_EN
          sum_d   = sum_q + {{ADDR_WIDTH{coeff_q[DATA_WIDTH-1]}}, coeff_q};
`endif
          if (addr_q == LAST_ADDR) begin
            flag_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      coeff_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      coeff_q <= coeff_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      flag_q  <= flag_d;
`ifdef COEFF_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign romAddress       = addr_q;
  assign coefficient_out  = coeff_q;
  assign coefficientValid = valid_q;
  assign busy             = busy_q;
  assign filterSetFlag    = flag_q;
`ifdef COEFF_CHECKSUM_EN
  assign coefficientSum   = sum_q;
`endif

endmodule

// File: tb/tb_coefficient_load_controller.sv
// Directed bench for coefficient_load_controller; sum checks apply when COEFF_CHECKSUM_EN is defined.
module tb_coefficient_load_controller;

  logic clock;
  logic reset;
  logic start;
  logic start1;
  logic filterReady;

  logic [4:0]        romAddress;
  logic signed [7:0] romData;
  logic signed [7:0] coefficient_out;
  logic              coefficientValid;
  logic              busy;
  logic              filterSetFlag;

  logic [4:0]        romAddress1;
  logic signed [7:0] romData1;
  logic signed [7:0] coefficient_out1;
  logic              coefficientValid1;
  logic              busy1;
  logic              filterSetFlag1;
`ifdef COEFF_CHECKSUM_EN
  logic signed [12:0] coefficientSum;
  logic signed [12:0] coefficientSum1;
`endif

  int tab [20] = '{34, 34, 0, 49, 125, -77, 60, -20, 45, 30,
                   -10, 70, 25, -5, 40, 15, 20, 20, -97, 10};

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit pulse_en = 1'b0;

  coefficient_load_controller #(.LENGTH(20), .DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .start(start),
    .romAddress(romAddress), .romData(romData), .filterReady(filterReady),
    .coefficient_out(coefficient_out), .coefficientValid(coefficientValid),
    .busy(busy), .filterSetFlag(filterSetFlag)
`ifdef COEFF_CHECKSUM_EN
    , .coefficientSum(coefficientSum)
`endif
  );

  coefficient_load_controller #(.LENGTH(1), .DATA_WIDTH(8), .ADDR_WIDTH(5)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .romAddress(romAddress1), .romData(romData1), .filterReady(1'b1),
    .coefficient_out(coefficient_out1), .coefficientValid(coefficientValid1),
    .busy(busy1), .filterSetFlag(filterSetFlag1)
`ifdef COEFF_CHECKSUM_EN
    , .coefficientSum(coefficientSum1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read ROM models.
  always @(posedge clock) begin
    romData  <= (romAddress < 5'd20) ? 8'(tab[romAddress]) : 8'sd0;
    romData1 <= -8'sd128;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    start = pulse_en && (cyc == 5 || cyc == 20);
  endtask

  task automatic run_load(input int stall_k, input int stall_n, input bit pulses);
    cyc = 0;
    pulse_en = pulses;
    filterReady = 1'b1;
    start = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      chk("addr_busy", busy, 1);
      chk("addr_valid", coefficientValid, 0);
      chk("addr_rom", romAddress, k);
      chk("addr_flag", filterSetFlag, 0);
      tick();
      chk("read_valid", coefficientValid, 0);
      chk("read_rom", romAddress, k);
      tick();
      if (k == stall_k) begin
        for (int s = 0; s < stall_n; s++) begin
          filterReady = 1'b0;
          chk("stall_valid", coefficientValid, 1);
          chk("stall_coeff", $signed(coefficient_out), tab[k]);
          chk("stall_rom", romAddress, k);
          tick();
        end
      end
      filterReady = 1'b1;
      chk("load_valid", coefficientValid, 1);
      chk("load_coeff", $signed(coefficient_out), tab[k]);
      chk("load_rom", romAddress, k);
      chk("load_busy", busy, 1);
      tick();
    end
    chk("done_flag", filterSetFlag, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", coefficientValid, 0);
    chk("done_rom", romAddress, 19);
`ifdef COEFF_CHECKSUM_EN
    chk("done_sum", $signed(coefficientSum), 368);
`endif
    tick();
    chk("done_flag_hold", filterSetFlag, 1);
    chk("done_busy_hold", busy, 0);
    pulse_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    filterReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rom", romAddress, 0);
    chk("rst_coeff", $signed(coefficient_out), 0);
    chk("rst_valid", coefficientValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flag", filterSetFlag, 0);
`ifdef COEFF_CHECKSUM_EN
    chk("rst_sum", $signed(coefficientSum), 0);
`endif
    reset = 1'b0;

    // Plain load from IDLE: DONE at cycle 61.
    run_load(-1, 0, 1'b0);
    // Start from DONE with a 4-cycle stall on coefficient 5: DONE at cycle 65.
    run_load(5, 4, 1'b0);
    // Start pulses at cycles 5 and 20 during a load are ignored.
    run_load(-1, 0, 1'b1);

    // Reset at cycle 30 abandons the load.
    cyc = 0;
    filterReady = 1'b1;
    start = 1'b1;
    tick();
    repeat (29) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_rom", romAddress, 0);
    chk("mid_rst_coeff", $signed(coefficient_out), 0);
    chk("mid_rst_valid", coefficientValid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flag", filterSetFlag, 0);
`ifdef COEFF_CHECKSUM_EN
    chk("mid_rst_sum", $signed(coefficientSum), 0);
`endif
    for (int i = 0; i < 70; i++) begin
      tick();
      chk("post_rst_flag", filterSetFlag, 0);
    end

    // LENGTH=1 table {-128}: handshake at cycle 3, flag at cycle 4.
    cyc = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("len1_busy", busy1, 1);
    chk("len1_rom", romAddress1, 0);
    tick();
    chk("len1_read_valid", coefficientValid1, 0);
    tick();
    chk("len1_valid", coefficientValid1, 1);
    chk("len1_coeff", $signed(coefficient_out1), -128);
    chk("len1_flag_early", filterSetFlag1, 0);
    tick();
    chk("len1_flag", filterSetFlag1, 1);
    chk("len1_done_busy", busy1, 0);
    chk("len1_done_valid", coefficientValid1, 0);
`ifdef COEFF_CHECKSUM_EN
    chk("len1_sum", $signed(coefficientSum1), -128);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
